// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle control FSM.
// The MIPS64_EN macro adds LD/SD/DADDI support in the opcode decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtExe  = 4'd6,
        StImmExe = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        ClsIllegal,
        ClsLoad,
        ClsStore,
        ClsRtype,
        ClsImm,
        ClsBeq,
        ClsBne,
        ClsJump
    } op_class_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpDaddi = 6'b011000;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpLbu   = 6'b100100;
    localparam logic [5:0] OpSb    = 6'b101000;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpLd    = 6'b110111;
    localparam logic [5:0] OpSd    = 6'b111111;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluAnd   = 3'b100;
    localparam logic [2:0] AluSlt   = 3'b101;
    localparam logic [2:0] AluDadd  = 3'b110;

    localparam logic [1:0] MemWord  = 2'b00;
    localparam logic [1:0] MemByteU = 2'b01;
    localparam logic [1:0] MemByteS = 2'b10;
    localparam logic [1:0] MemDword = 2'b11;

    localparam logic [1:0] SrcbRegB  = 2'b00;
    localparam logic [1:0] SrcbFour  = 2'b01;
    localparam logic [1:0] SrcbImm   = 2'b10;
    localparam logic [1:0] SrcbImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic       branch;
        logic       branchne;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic [1:0] memsize;
    } ctrl_t;

    // Control word to hold while sitting in state st; op fields are stable from DECODE on.
    function automatic ctrl_t state_ctrl(state_e st, op_class_e cls, logic [2:0] imm_aluop,
                                         logic [1:0] memsize);
        ctrl_t c;
        c = '0;
        unique case (st)
            StFetch:  c.alusrcb = SrcbFour;
            StDecode: c.alusrcb = SrcbImmSh;
            StMemAdr: begin
                c.alusrca = 1'b1;
                c.alusrcb = SrcbImm;
            end
            StMemRd: begin
                c.iord    = 1'b1;
                c.memsize = memsize;
            end
            StMemWb: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                c.memsize  = memsize;
            end
            StMemWr: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                c.memsize  = memsize;
            end
            StRtExe: begin
                c.alusrca = 1'b1;
                c.alusrcb = SrcbRegB;
                c.aluop   = AluFunct;
            end
            StImmExe: begin
                c.alusrca = 1'b1;
                c.alusrcb = SrcbImm;
                c.aluop   = imm_aluop;
            end
            StAluWb: begin
                c.regwrite = 1'b1;
                c.regdst   = (cls == ClsRtype);
            end
            StBranch: begin
                c.alusrca  = 1'b1;
                c.alusrcb  = SrcbRegB;
                c.aluop    = AluSub;
                c.pcsrc    = PcAluOut;
                c.branch   = (cls == ClsBeq);
                c.branchne = (cls == ClsBne);
            end
            StJump: begin
                c.pcsrc   = PcJump;
                c.pcwrite = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier for the multicycle control FSM.
// LD/SD/DADDI are recognised only when MIPS64_EN is defined.
module mc_opdecode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output op_class_e  op_class,
    output logic [2:0] imm_aluop,
    output logic [1:0] memsize,
    output logic       legal
);

    always_comb begin
        op_class  = ClsIllegal;
        imm_aluop = AluAdd;
        memsize   = MemWord;
        case (op)
            OpLw:    op_class = ClsLoad;
            OpLbu: begin
                op_class = ClsLoad;
                memsize  = MemByteU;
            end
            OpLb: begin
                op_class = ClsLoad;
                memsize  = MemByteS;
            end
            OpSw:    op_class = ClsStore;
            OpSb: begin
                op_class = ClsStore;
                memsize  = MemByteS;
            end
            OpRtype: op_class = ClsRtype;
            OpAddi:  op_class = ClsImm;
            OpAndi: begin
                op_class  = ClsImm;
                imm_aluop = AluAnd;
            end
            OpOri: begin
                op_class  = ClsImm;
                imm_aluop = AluOr;
            end
            OpSlti: begin
                op_class  = ClsImm;
                imm_aluop = AluSlt;
            end
            OpBeq:   op_class = ClsBeq;
            OpBne:   op_class = ClsBne;
            OpJ:     op_class = ClsJump;
`ifdef MIPS64_EN
            OpLd: begin
                op_class = ClsLoad;
                memsize  = MemDword;
            end
            OpSd: begin
                op_class = ClsStore;
                memsize  = MemDword;
            end
            OpDaddi: begin
                op_class  = ClsImm;
                imm_aluop = AluDadd;
            end
`endif
            default: ;
        endcase
        legal = (op_class != ClsIllegal);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with registered control outputs.
// Define MIPS64_EN to enable the LD/SD/DADDI opcodes.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic       branch,
    output logic       branchne,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic [1:0] memsize,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_e    state_q, state_d;
    ctrl_t     ctrl_q, ctrl_d;
    op_class_e op_class;
    logic [2:0] imm_aluop;
    logic [1:0] dec_memsize;
    logic       legal;
    logic       ready;
    logic       fetch_go;

    mc_opdecode u_opdecode (
        .op        (op),
        .op_class  (op_class),
        .imm_aluop (imm_aluop),
        .memsize   (dec_memsize),
        .legal     (legal)
    );

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = ready ? StDecode : StFetch;
            StDecode: begin
                case (op_class)
                    ClsLoad, ClsStore: state_d = StMemAdr;
                    ClsRtype:          state_d = StRtExe;
                    ClsImm:            state_d = StImmExe;
                    ClsBeq, ClsBne:    state_d = StBranch;
                    ClsJump:           state_d = StJump;
                    default:           state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (op_class == ClsLoad) ? StMemRd : StMemWr;
            StMemRd:  state_d = ready ? StMemWb : StMemRd;
            StMemWr:  state_d = ready ? StFetch : StMemWr;
            StRtExe,
            StImmExe: state_d = StAluWb;
            default:  state_d = StFetch;
        endcase
        ctrl_d = state_ctrl(state_d, op_class, imm_aluop, dec_memsize);
    end

    // Outputs are registered alongside the state so they change only with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StFetch;
            ctrl_q          <= '0;
            ctrl_q.alusrcb  <= SrcbFour;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Fetch strobes follow mem_ready within the cycle, so they cannot be registered.
    assign fetch_go   = (state_q == StFetch) && reset && ready;
    assign irwrite    = fetch_go;
    assign pcwrite    = ctrl_q.pcwrite | fetch_go;
    assign illegal_op = (state_q == StDecode) && !legal;

    assign regwrite = ctrl_q.regwrite;
    assign memwrite = ctrl_q.memwrite;
    assign iord     = ctrl_q.iord;
    assign memtoreg = ctrl_q.memtoreg;
    assign regdst   = ctrl_q.regdst;
    assign alusrca  = ctrl_q.alusrca;
    assign branch   = ctrl_q.branch;
    assign branchne = ctrl_q.branchne;
    assign alusrcb  = ctrl_q.alusrcb;
    assign pcsrc    = ctrl_q.pcsrc;
    assign aluop    = ctrl_q.aluop;
    assign memsize  = ctrl_q.memsize;
    assign state_o  = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction-level reference schedule plus directed cases.
// Honours MIPS64_EN the same way the design does.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [5:0] op;

    logic       pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic       branch, branchne, illegal_op;
    logic [1:0] alusrcb, pcsrc, memsize;
    logic [2:0] aluop;
    logic [3:0] state_o;

    logic       n_pcwrite, n_irwrite, n_regwrite, n_memwrite, n_iord, n_memtoreg, n_regdst;
    logic       n_alusrca, n_branch, n_branchne, n_illegal_op;
    logic [1:0] n_alusrcb, n_pcsrc, n_memsize;
    logic [2:0] n_aluop;
    logic [3:0] n_state_o;

    int total = 0;
    int bad   = 0;

    mc_ctrl_fsm u_dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .branch(branch), .branchne(branchne), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .memsize(memsize), .illegal_op(illegal_op), .state_o(state_o)
    );

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0)) u_dut_nohs (
        .clk(clk), .reset(reset), .op(op), .mem_ready(1'b0),
        .pcwrite(n_pcwrite), .irwrite(n_irwrite), .regwrite(n_regwrite),
        .memwrite(n_memwrite), .iord(n_iord), .memtoreg(n_memtoreg), .regdst(n_regdst),
        .alusrca(n_alusrca), .branch(n_branch), .branchne(n_branchne),
        .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .aluop(n_aluop), .memsize(n_memsize),
        .illegal_op(n_illegal_op), .state_o(n_state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mw, iord, m2r, rdst, asa, br, brne, ill;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        logic [1:0] msz;
    } vec_t;

    localparam int PhFetch = 0, PhDecode = 1, PhMemAdr = 2, PhMemRd = 3, PhMemWb = 4;
    localparam int PhMemWr = 5, PhRtExe = 6, PhImmExe = 7, PhAluWb = 8, PhBranch = 9;
    localparam int PhJump = 10;

    int plan_q[$];

    function automatic string kind(logic [5:0] o);
        case (o)
            6'b100011, 6'b100000, 6'b100100: return "load";
            6'b101011, 6'b101000:            return "store";
            6'b000000:                       return "rtype";
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return "imm";
            6'b000100:                       return "beq";
            6'b000101:                       return "bne";
            6'b000010:                       return "jump";
`ifdef MIPS64_EN
            6'b110111:                       return "load";
            6'b111111:                       return "store";
            6'b011000:                       return "imm";
`endif
            default:                         return "bad";
        endcase
    endfunction

    function automatic logic [1:0] size_of(logic [5:0] o);
        case (o)
            6'b100100:            return 2'b01;
            6'b100000, 6'b101000: return 2'b10;
            6'b110111, 6'b111111: return 2'b11;
            default:              return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] immop_of(logic [5:0] o);
        case (o)
            6'b001100: return 3'b100;
            6'b001101: return 3'b011;
            6'b001010: return 3'b101;
            6'b011000: return 3'b110;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic void make_plan(logic [5:0] o);
        string k;
        k = kind(o);
        plan_q = {PhFetch, PhDecode};
        if (k == "load")       plan_q = {plan_q, PhMemAdr, PhMemRd, PhMemWb};
        else if (k == "store") plan_q = {plan_q, PhMemAdr, PhMemWr};
        else if (k == "rtype") plan_q = {plan_q, PhRtExe, PhAluWb};
        else if (k == "imm")   plan_q = {plan_q, PhImmExe, PhAluWb};
        else if (k == "beq" || k == "bne") plan_q.push_back(PhBranch);
        else if (k == "jump")  plan_q.push_back(PhJump);
    endfunction

    function automatic vec_t expect_of(int ph, logic [5:0] o, logic rdy);
        vec_t  e;
        string k;
        e = '0;
        k = kind(o);
        case (ph)
            PhFetch:  begin e.st = StFetch; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            PhDecode: begin e.st = StDecode; e.asb = 2'b11; e.ill = (k == "bad"); end
            PhMemAdr: begin e.st = StMemAdr; e.asa = 1'b1; e.asb = 2'b10; end
            PhMemRd:  begin e.st = StMemRd; e.iord = 1'b1; e.msz = size_of(o); end
            PhMemWb:  begin e.st = StMemWb; e.m2r = 1'b1; e.rw = 1'b1; e.msz = size_of(o); end
            PhMemWr:  begin
                e.st = StMemWr; e.iord = 1'b1; e.mw = 1'b1; e.msz = size_of(o);
            end
            PhRtExe:  begin e.st = StRtExe; e.asa = 1'b1; e.aop = 3'b010; end
            PhImmExe: begin e.st = StImmExe; e.asa = 1'b1; e.asb = 2'b10; e.aop = immop_of(o); end
            PhAluWb:  begin e.st = StAluWb; e.rw = 1'b1; e.rdst = (k == "rtype"); end
            PhBranch: begin
                e.st = StBranch; e.asa = 1'b1; e.aop = 3'b001; e.pcs = 2'b01;
                e.br = (k == "beq"); e.brne = (k == "bne");
            end
            PhJump:   begin e.st = StJump; e.pcs = 2'b10; e.pcw = 1'b1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v.st = state_o;   v.pcw = pcwrite;   v.irw = irwrite;  v.rw = regwrite;
        v.mw = memwrite;  v.iord = iord;     v.m2r = memtoreg; v.rdst = regdst;
        v.asa = alusrca;  v.br = branch;     v.brne = branchne; v.ill = illegal_op;
        v.asb = alusrcb;  v.pcs = pcsrc;     v.aop = aluop;    v.msz = memsize;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from its FETCH cycle; time must be just after a rising edge.
    task automatic run_instr(input logic [5:0] o, input bit rand_stall, input string name);
        vec_t exp_v, obs_v;
        logic rdy;
        bit   waits;
        op = o;
        make_plan(o);
        foreach (plan_q[i]) begin
            waits = (plan_q[i] == PhFetch || plan_q[i] == PhMemRd || plan_q[i] == PhMemWr);
            for (int c = 0; c < 16; c++) begin
                if (rand_stall && (!waits || c < 5)) rdy = 1'($urandom_range(0, 1));
                else                                 rdy = 1'b1;
                mem_ready = rdy;
                @(negedge clk);
                exp_v = expect_of(plan_q[i], o, rdy);
                obs_v = observe();
                total++;
                if (obs_v !== exp_v) begin
                    bad++;
                    $display("FAIL %s op=%b step=%0d cyc=%0d got=%h want=%h",
                             name, o, i, c, obs_v, exp_v);
                end
                @(posedge clk);
                #1;
                if (!waits || rdy) break;
            end
        end
    endtask

    task automatic test_reset();
        vec_t exp_v;
        reset = 1'b0;
        mem_ready = 1'b1;
        op = 6'b100011;
        repeat (2) @(negedge clk);
        exp_v = expect_of(PhFetch, op, 1'b0);
        total++;
        if (observe() !== exp_v) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", observe(), exp_v);
        end
        total++;
        if (n_state_o !== 4'(StFetch) || n_irwrite !== 1'b0) begin
            bad++;
            $display("FAIL reset_nohs got st=%0d irw=%b want st=0 irw=0", n_state_o, n_irwrite);
        end
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_instr(6'b100011, 1'b0, "lw");
        run_instr(6'b101011, 1'b0, "sw");
        run_instr(6'b000101, 1'b0, "bne");
        run_instr(6'b000100, 1'b0, "beq");
        run_instr(6'b000000, 1'b0, "rtype");
        run_instr(6'b000010, 1'b0, "jump");
        run_instr(6'b011000, 1'b0, "daddi");
        run_instr(6'b110111, 1'b0, "ld");
        run_instr(6'b111111, 1'b1, "sd");
        run_instr(6'b100100, 1'b1, "lbu");
        run_instr(6'b111110, 1'b0, "bad_op");
    endtask

    task automatic test_store_stall();
        int mw_cycles;
        do_reset();
        op = 6'b101011;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mw_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            @(negedge clk);
            if (memwrite === 1'b1) mw_cycles++;
            @(posedge clk);
            #1;
        end
        total++;
        if (mw_cycles != 4 || state_o !== 4'(StFetch)) begin
            bad++;
            $display("FAIL store_stall got mw=%0d st=%0d want mw=4 st=0", mw_cycles, state_o);
        end
    endtask

    task automatic test_abort();
        do_reset();
        op = 6'b101011;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (memwrite !== 1'b1 || state_o !== 4'(StMemWr)) begin
            bad++;
            $display("FAIL abort_pre got mw=%b st=%0d want mw=1 st=5", memwrite, state_o);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (memwrite !== 1'b0 || state_o !== 4'(StFetch)) begin
            bad++;
            $display("FAIL abort_async got mw=%b st=%0d want mw=0 st=0", memwrite, state_o);
        end
        mem_ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        total++;
        if (irwrite !== 1'b1 || state_o !== 4'(StFetch)) begin
            bad++;
            $display("FAIL abort_release got irw=%b st=%0d want irw=1 st=0", irwrite, state_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (state_o !== 4'(StDecode)) begin
            bad++;
            $display("FAIL abort_next got st=%0d want st=1", state_o);
        end
    endtask

    task automatic test_no_handshake();
        logic [3:0] exp_st[5];
        exp_st = '{4'(StFetch), 4'(StDecode), 4'(StImmExe), 4'(StAluWb), 4'(StFetch)};
        @(negedge clk);
        op = 6'b001101;
        mem_ready = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (n_state_o !== exp_st[i] || (i == 0 && n_irwrite !== 1'b1) ||
                (i == 2 && n_aluop !== 3'b011) || (i == 3 && n_regwrite !== 1'b1)) begin
                bad++;
                $display("FAIL nohs_ori cyc=%0d got st=%0d irw=%b aop=%b rw=%b want st=%0d",
                         i, n_state_o, n_irwrite, n_aluop, n_regwrite, exp_st[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] pool[16];
        logic [5:0] o;
        pool = '{6'b100011, 6'b100000, 6'b100100, 6'b101011, 6'b101000, 6'b000000,
                 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000100, 6'b000101,
                 6'b000010, 6'b110111, 6'b111111, 6'b011000};
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0) o = pool[$urandom_range(0, 15)];
            else                           o = 6'($urandom);
            run_instr(o, 1'b1, "random");
        end
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state_o !== 4'(StFetch)) begin
            bad++;
            $display("FAIL random_end got st=%0d want st=0", state_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_store_stall();
        test_abort();
        test_no_handshake();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
